// File: rtl/residu_filt_pkg.sv
// LPC residual filter: frame constants, FSM encoding, helpers.
// Optional overflow flag in residu_filt is enabled by RESIDU_OVF_FLAG_EN.
package residu_filt_pkg;

  localparam logic [5:0]  L     = 6'd40;
  localparam logic [5:0]  M     = 6'd10;
  localparam logic [15:0] SHIFT = 16'd3;
  localparam logic [31:0] RND   = 32'h0000_8000;

  // Default scratch-memory blocks (64-word aligned)
  localparam logic [10:0] X_BASE = 11'h040;
  localparam logic [10:0] A_BASE = 11'h080;
  localparam logic [10:0] Y_BASE = 11'h0C0;

  typedef enum logic [3:0] {
    S_INIT,
    S_OUTER,
    S_RD_X0,
    S_MULT0,
    S_INNER,
    S_RD_A,
    S_MAC,
    S_SHL1,
    S_SHL2,
    S_ROUND,
    S_INC
  } state_t;

  function automatic logic [31:0] sext16(
    input logic [15:0] v
  );
    return {{16{v[15]}}, v};
  endfunction

endpackage

// File: rtl/residu_filt.sv
// LPC residual y[n] = round(shl(sum a[j]*x[n-j], SHIFT)) over one frame.
// Define RESIDU_OVF_FLAG_EN to add the sticky ovfFlag output.
module residu_filt
  import residu_filt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [10:0] xAddr,
  input  logic [10:0] aAddr,
  input  logic [10:0] yAddr,
  input  logic [31:0] memIn,
  output logic [10:0] memWriteAddr,
  output logic        memWriteEn,
  output logic [31:0] memOut,
  output logic [15:0] L_multOutA,
  output logic [15:0] L_multOutB,
  input  logic [31:0] L_multIn,
  output logic [15:0] L_macOutA,
  output logic [15:0] L_macOutB,
  output logic [31:0] L_macOutC,
  input  logic [31:0] L_macIn,
  output logic [31:0] L_addOutA,
  output logic [31:0] L_addOutB,
  input  logic [31:0] L_addIn,
  output logic [31:0] L_shlOutVar1,
  output logic [15:0] L_shlNumShiftOut,
  output logic        L_shlReady,
  input  logic        L_shlDone,
  input  logic [31:0] L_shlIn,
  output logic        done
`ifdef RESIDU_OVF_FLAG_EN
  ,
  output logic        ovfFlag
`endif
);

  state_t      state;
  logic [5:0]  i;
  logic [5:0]  j;
  logic [31:0] s;
  logic [15:0] tx;
  logic [15:0] ta;

  logic unused;
  assign unused = ^{xAddr[5:0], aAddr[5:0], yAddr[5:0],
                    memIn[31:16], L_addIn[15:6]};

  always_comb begin
    memWriteAddr     = '0;
    memWriteEn       = 1'b0;
    memOut           = '0;
    L_multOutA       = '0;
    L_multOutB       = '0;
    L_macOutA        = '0;
    L_macOutB        = '0;
    L_macOutC        = '0;
    L_addOutA        = '0;
    L_addOutB        = '0;
    L_shlOutVar1     = '0;
    L_shlNumShiftOut = '0;
    L_shlReady       = 1'b0;
    done             = 1'b0;
    case (state)
      S_INIT: ;
      S_OUTER: begin
        if (i >= L) done = 1'b1;
        else memWriteAddr = {xAddr[10:6], M + i};
      end
      S_RD_X0:
        memWriteAddr = {aAddr[10:6], 6'd0};
      S_MULT0: begin
        L_multOutA = tx;
        L_multOutB = memIn[15:0];
      end
      S_INNER: begin
        if (j <= M) memWriteAddr = {aAddr[10:6], j};
      end
      // offset M+i-j stays >= 0 since j <= M
      S_RD_A:
        memWriteAddr = {xAddr[10:6], M + i - j};
      S_MAC: begin
        L_macOutA = ta;
        L_macOutB = memIn[15:0];
        L_macOutC = s;
        L_addOutA = {26'd0, j};
        L_addOutB = 32'd1;
      end
      S_SHL1: begin
        L_shlOutVar1     = s;
        L_shlNumShiftOut = SHIFT;
        L_shlReady       = 1'b1;
      end
      S_SHL2: ;
      S_ROUND: begin
        L_addOutA    = s;
        L_addOutB    = RND;
        memWriteAddr = {yAddr[10:6], i};
        memWriteEn   = 1'b1;
        memOut       = sext16(L_addIn[31:16]);
      end
      S_INC: begin
        L_addOutA = {26'd0, i};
        L_addOutB = 32'd1;
      end
      default: done = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_INIT;
      i     <= '0;
      j     <= '0;
      s     <= '0;
      tx    <= '0;
      ta    <= '0;
    end else begin
      case (state)
        S_INIT: begin
          i <= '0;
          if (start) state <= S_OUTER;
        end
        S_OUTER:
          state <= (i >= L) ? S_INIT : S_RD_X0;
        S_RD_X0: begin
          tx    <= memIn[15:0];
          state <= S_MULT0;
        end
        S_MULT0: begin
          s     <= L_multIn;
          j     <= 6'd1;
          state <= S_INNER;
        end
        S_INNER:
          state <= (j > M) ? S_SHL1 : S_RD_A;
        S_RD_A: begin
          ta    <= memIn[15:0];
          state <= S_MAC;
        end
        S_MAC: begin
          s     <= L_macIn;
          j     <= L_addIn[5:0];
          state <= S_INNER;
        end
        S_SHL1:
          state <= S_SHL2;
        S_SHL2: begin
          if (L_shlDone) begin
            s     <= L_shlIn;
            state <= S_ROUND;
          end
        end
        S_ROUND:
          state <= S_INC;
        S_INC: begin
          i     <= L_addIn[5:0];
          state <= S_OUTER;
        end
        default:
          state <= S_INIT;
      endcase
    end
  end

`ifdef RESIDU_OVF_FLAG_EN
  // Sticky across the frame; only a new start clears it
  always_ff @(posedge clk) begin
    if (!reset) begin
      ovfFlag <= 1'b0;
    end else if (state == S_INIT && start) begin
      ovfFlag <= 1'b0;
    end else if (state == S_SHL2 && L_shlDone &&
                 (L_shlIn == 32'h7FFF_FFFF ||
                  L_shlIn == 32'h8000_0000)) begin
      ovfFlag <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_residu_filt.sv
// Directed scoreboard bench for residu_filt.
// Models scratch memory and the saturating L_* units.
module tb_residu_filt;

  localparam int XI = 64;
  localparam int AI = 128;
  localparam int YI = 192;
  localparam logic [10:0] XB = 11'h047;
  localparam logic [10:0] AB = 11'h09A;
  localparam logic [10:0] YB = 11'h0C3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] memIn = '0;
  logic [10:0] memWriteAddr;
  logic        memWriteEn;
  logic [31:0] memOut;
  logic [15:0] L_multOutA, L_multOutB;
  logic [31:0] L_multIn;
  logic [15:0] L_macOutA, L_macOutB;
  logic [31:0] L_macOutC, L_macIn;
  logic [31:0] L_addOutA, L_addOutB, L_addIn;
  logic [31:0] L_shlOutVar1, L_shlIn;
  logic [15:0] L_shlNumShiftOut;
  logic        L_shlReady, L_shlDone;
  logic        done;
`ifdef RESIDU_OVF_FLAG_EN
  logic        ovfFlag;
`endif

  residu_filt dut (
    .clk(clk), .reset(reset), .start(start),
    .xAddr(XB), .aAddr(AB), .yAddr(YB),
    .memIn(memIn),
    .memWriteAddr(memWriteAddr),
    .memWriteEn(memWriteEn), .memOut(memOut),
    .L_multOutA(L_multOutA), .L_multOutB(L_multOutB),
    .L_multIn(L_multIn),
    .L_macOutA(L_macOutA), .L_macOutB(L_macOutB),
    .L_macOutC(L_macOutC), .L_macIn(L_macIn),
    .L_addOutA(L_addOutA), .L_addOutB(L_addOutB),
    .L_addIn(L_addIn),
    .L_shlOutVar1(L_shlOutVar1),
    .L_shlNumShiftOut(L_shlNumShiftOut),
    .L_shlReady(L_shlReady), .L_shlDone(L_shlDone),
    .L_shlIn(L_shlIn),
    .done(done)
`ifdef RESIDU_OVF_FLAG_EN
    , .ovfFlag(ovfFlag)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0;
  int done_cnt = 0;

  function automatic logic [31:0] sat(input longint v);
    if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (v < -64'sd2147483648) return 32'h8000_0000;
    return v[31:0];
  endfunction

  function automatic logic [31:0] m_add(
    input logic [31:0] a, input logic [31:0] b);
    return sat(longint'($signed(a)) + longint'($signed(b)));
  endfunction

  function automatic logic [31:0] m_mult(
    input logic [15:0] a, input logic [15:0] b);
    if (a == 16'h8000 && b == 16'h8000) return 32'h7FFF_FFFF;
    return sat(2 * longint'($signed(a)) * longint'($signed(b)));
  endfunction

  function automatic logic [31:0] m_shl(
    input logic [31:0] v, input logic [15:0] n);
    return sat(longint'($signed(v)) <<< n[4:0]);
  endfunction

  assign L_multIn = m_mult(L_multOutA, L_multOutB);
  assign L_macIn  = m_add(L_macOutC, m_mult(L_macOutA, L_macOutB));
  assign L_addIn  = m_add(L_addOutA, L_addOutB);

  // shifter: answers shl_delay cycles after the single-cycle latency
  int          shl_delay = 0;
  int          shl_cnt = 0;
  logic        shl_pend = 1'b0;
  logic [31:0] shl_res = '0;
  always @(posedge clk) begin
    if (!reset) begin
      shl_pend <= 1'b0;
    end else if (L_shlReady) begin
      shl_pend <= 1'b1;
      shl_cnt  <= shl_delay;
      shl_res  <= m_shl(L_shlOutVar1, L_shlNumShiftOut);
    end else if (shl_pend && shl_cnt == 0) begin
      shl_pend <= 1'b0;
    end else if (shl_pend) begin
      shl_cnt <= shl_cnt - 1;
    end
  end
  assign L_shlDone = shl_pend && shl_cnt == 0;
  assign L_shlIn   = shl_res;

  logic [31:0] mem [0:2047];
  logic        tb_we = 1'b0;
  logic [10:0] tb_a = '0;
  logic [31:0] tb_d = '0;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    memIn <= {16'hA5A5, mem[memWriteAddr][15:0]};
    if (tb_we) mem[tb_a] <= tb_d;
    else if (memWriteEn) mem[memWriteAddr] <= memOut;
  end

  logic [15:0] xv [50];
  logic [15:0] av [11];
  logic [10:0] exp_addr [$];
  logic [31:0] exp_data [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (memWriteEn) begin
      wr_cnt++;
      chk("write_expected", 32'(exp_addr.size() > 0), 32'd1);
      if (exp_addr.size() > 0) begin
        chk("y_addr", 32'(memWriteAddr), 32'(exp_addr.pop_front()));
        chk("y_data", memOut, exp_data.pop_front());
      end
    end
    if (done) done_cnt++;
  end

  task automatic wmem(input int a, input logic [31:0] d);
    @(negedge clk);
    tb_we = 1'b1;
    tb_a  = 11'(a);
    tb_d  = d;
  endtask

  task automatic load();
    for (int k = 0; k < 50; k++)
      wmem(XI + k, {{16{xv[k][15]}}, xv[k]});
    for (int k = 0; k < 11; k++)
      wmem(AI + k, {16'h0, av[k]});
    for (int k = 0; k < 40; k++)
      wmem(YI + k, 32'hDEAD_BEEF);
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  task automatic push_frame();
    logic [31:0] s, r;
    for (int n = 0; n < 40; n++) begin
      s = m_mult(av[0], xv[n + 10]);
      for (int k = 1; k <= 10; k++)
        s = m_add(s, m_mult(av[k], xv[n + 10 - k]));
      s = m_shl(s, 16'd3);
      r = m_add(s, 32'h8000);
      exp_addr.push_back(11'(YI + n));
      exp_data.push_back({{16{r[31]}}, r[31:16]});
    end
  endtask

  task automatic wait_done(output int d);
    d = -1;
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        return;
      end
    end
  endtask

  task automatic run_frame(output int lat);
    int c0, d;
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    @(negedge clk);
    start = 1'b0;
    wait_done(d);
    lat = (d < 0) ? -1 : d - c0;
  endtask

  task automatic set_identity();
    for (int k = 0; k < 11; k++) av[k] = 16'h0;
    av[0] = 16'd4096;
    for (int k = 0; k < 10; k++) xv[k] = 16'h0;
    for (int n = 0; n < 40; n++) xv[n + 10] = 16'(100 * n);
  endtask

  int lat, d1, d2, c0, base, dc;

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_we", 32'(memWriteEn), 32'd0);
    chk("rst_addr", 32'(memWriteAddr), 32'd0);
    chk("rst_shl_ready", 32'(L_shlReady), 32'd0);
    chk("rst_add_a", L_addOutA, 32'd0);
    reset = 1'b1;

    // 1: identity
    set_identity();
    load();
    push_frame();
    run_frame(lat);
    chk("t1_latency", 32'(lat), 32'd1521);
    chk("t1_drained", 32'(exp_addr.size()), 32'd0);
    chk("t1_y5", mem[YI + 5], 32'd500);
    chk("t1_y39", mem[YI + 39], 32'd3900);
`ifdef RESIDU_OVF_FLAG_EN
    chk("t1_ovf", 32'(ovfFlag), 32'd0);
`endif

    // 2: difference filter
    for (int k = 0; k < 50; k++) xv[k] = 16'h0;
    av[1] = 16'hF000;
    xv[9] = 16'd50;
    xv[10] = 16'd100;
    xv[11] = 16'd30;
    load();
    push_frame();
    run_frame(lat);
    chk("t2_latency", 32'(lat), 32'd1521);
    chk("t2_y0", mem[YI + 0], 32'd50);
    chk("t2_y1", mem[YI + 1], 32'hFFFF_FFBA);
    chk("t2_y2", mem[YI + 2], 32'hFFFF_FFE2);

    // 2b: pseudo-random taps and history
    for (int k = 0; k < 11; k++)
      av[k] = 16'($urandom_range(0, 4000) - 2000);
    for (int k = 0; k < 50; k++)
      xv[k] = 16'($urandom_range(0, 20000) - 10000);
    load();
    push_frame();
    run_frame(lat);
    chk("t2b_drained", 32'(exp_addr.size()), 32'd0);

    // 3: saturation
    for (int k = 0; k < 11; k++) av[k] = 16'h0;
    av[0] = 16'd4096;
    av[1] = 16'd4096;
    for (int k = 0; k < 50; k++)
      xv[k] = (k >= 9) ? 16'd32767 : 16'd0;
    load();
    push_frame();
    run_frame(lat);
    chk("t3_y0", mem[YI + 0], 32'h0000_7FFF);
    chk("t3_y39", mem[YI + 39], 32'h0000_7FFF);
`ifdef RESIDU_OVF_FLAG_EN
    chk("t3_ovf", 32'(ovfFlag), 32'd1);
`endif

    // 4: stalled shifter
    set_identity();
    load();
    shl_delay = 5;
    push_frame();
    run_frame(lat);
    chk("t4_latency", 32'(lat), 32'd1721);
    chk("t4_y20", mem[YI + 20], 32'd2000);
    shl_delay = 0;

    // 5: reset mid-frame while i = 17
    load();
    push_frame();
    base = wr_cnt;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 2000 && wr_cnt < base + 17; k++)
      @(negedge clk);
    chk("t5_reached_i17", 32'(wr_cnt - base), 32'd17);
    repeat (10) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("t5_pending", 32'(exp_addr.size()), 32'd23);
    exp_addr.delete();
    exp_data.delete();
    chk("t5_idle_addr", 32'(memWriteAddr), 32'd0);
    dc = done_cnt;
    base = wr_cnt;
    repeat (60) @(negedge clk);
    chk("t5_no_done", 32'(done_cnt), 32'(dc));
    chk("t5_no_write", 32'(wr_cnt), 32'(base));
    push_frame();
    run_frame(lat);
    chk("t5_restart_latency", 32'(lat), 32'd1521);
    chk("t5_drained", 32'(exp_addr.size()), 32'd0);

    // 6: back-to-back with start held
    push_frame();
    push_frame();
    @(negedge clk);
    start = 1'b1;
    c0 = cyc;
    wait_done(d1);
    wait_done(d2);
    start = 1'b0;
    chk("t6_first", 32'(d1 - c0), 32'd1521);
    chk("t6_second", 32'(d2 - d1), 32'd1522);
    repeat (3) @(negedge clk);
    chk("t6_drained", 32'(exp_addr.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
